// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 key decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int FRAME_DATA_MSB = 7;
    localparam int FRAME_PAR_BIT  = 8;
    localparam int FRAME_STOP_BIT = 9;

    // Device replies (BAT ok, echo, ack, failures, resend, error) rather than keys.
    function automatic logic is_status(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_watchdog.sv
// Inter-byte watchdog: counts enabled cycles, clear dominates, pulses expire at TIMEOUT_CYCLES-1.
module ps2_key_ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    import ps2_pkg::*;

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    assign expire = en && !clr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset || clr || !en || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Turns raw PS/2 frames into key events (E0/F0 prefixes folded into flags) and status pulses.
// One-entry output register with valid/ready; events arriving while it is full are dropped.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [9:0] rx_frame,
    output logic       rx_inhibit,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       status_valid,
    output logic [7:0] status_code,
    output logic       timeout,
    output logic       overflow,
    output logic [7:0] err_cnt,
    input  logic       err_clr
);
    import ps2_pkg::*;

    dec_state_t state_q, state_d;

    logic [7:0] rx_byte;
    logic       frame_ok;
    logic       bad_frame;
    logic       ev_fire;
    logic       ev_ext;
    logic       ev_brk;
    logic       st_fire;
    logic       wd_expire;
    logic       accept;
    logic       load_ok;

    assign rx_byte  = rx_frame[FRAME_DATA_MSB:0];
    assign frame_ok = (^rx_frame[FRAME_PAR_BIT:0]) && rx_frame[FRAME_STOP_BIT];
    assign accept   = key_valid && key_ready;
    assign load_ok  = !key_valid || accept;

    ps2_key_ctrl_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr   (rx_valid),
        .en    (state_q != ST_IDLE),
        .expire(wd_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame always takes priority over a coincident watchdog expiry.
    always_comb begin
        state_d   = state_q;
        ev_fire   = 1'b0;
        ev_ext    = 1'b0;
        ev_brk    = 1'b0;
        st_fire   = 1'b0;
        bad_frame = 1'b0;
        if (rx_valid) begin
            if (!frame_ok) begin
                bad_frame = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_byte == PS2_EXT) begin
                            state_d = ST_EXT;
                        end else if (rx_byte == PS2_BRK) begin
                            state_d = ST_BRK;
                        end else if (is_status(rx_byte)) begin
                            st_fire = 1'b1;
                        end else begin
                            ev_fire = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (rx_byte == PS2_BRK) begin
                            state_d = ST_EXT_BRK;
                        end else if (rx_byte != PS2_EXT) begin
                            ev_fire = 1'b1;
                            ev_ext  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        ev_fire = 1'b1;
                        ev_brk  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    default: begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                        ev_brk  = 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end else if (wd_expire) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_valid    <= 1'b0;
            key_code     <= '0;
            key_ext      <= 1'b0;
            key_break    <= 1'b0;
            status_valid <= 1'b0;
            status_code  <= '0;
            timeout      <= 1'b0;
            overflow     <= 1'b0;
            err_cnt      <= '0;
            rx_inhibit   <= 1'b0;
        end else begin
            status_valid <= st_fire;
            timeout      <= wd_expire;
            rx_inhibit   <= key_valid && !key_ready;
            if (st_fire) begin
                status_code <= rx_byte;
            end

            if (ev_fire && load_ok) begin
                key_valid <= 1'b1;
                key_code  <= rx_byte;
                key_ext   <= ev_ext;
                key_break <= ev_brk;
            end else if (accept) begin
                key_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear must still be recorded.
            if (ev_fire && !load_ok) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end

            if (err_clr) begin
                err_cnt <= bad_frame ? 8'd1 : 8'd0;
            end else if (bad_frame && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: vector table, directed corner cases, randomized run vs model.
module tb_ps2_key_ctrl;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [9:0] rx_frame;
    logic       rx_inhibit;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       status_valid;
    logic [7:0] status_code;
    logic       timeout;
    logic       overflow;
    logic [7:0] err_cnt;
    logic       err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_key_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_frame    (rx_frame),
        .rx_inhibit  (rx_inhibit),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_break   (key_break),
        .status_valid(status_valid),
        .status_code (status_code),
        .timeout     (timeout),
        .overflow    (overflow),
        .err_cnt     (err_cnt),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] mk_frame(input logic [7:0] b, input logic good);
        logic p;
        p = ~^b;
        if (!good) p = ~p;
        return {1'b1, p, b};
    endfunction

    function automatic logic is_stat(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
               b == 8'hFC || b == 8'hFE || b == 8'hFF;
    endfunction

    task automatic send(input logic [9:0] f);
        @(negedge clk);
        rx_frame = f;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       good;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       st;
    } vec_t;

    vec_t vt[16];

    // Reference model state
    logic [7:0] pfx[$];
    logic       mv, mext, mbrk, mst, mov, minh, mto;
    logic [7:0] mcode, mstc, merr;

    task automatic model_step(input logic rv, input logic [9:0] fr, input logic kr, input logic ec);
        logic n_inh, acc, ev, bad, drop, has_e, has_f, e_ext, e_brk;
        logic [7:0] b, e_code;
        n_inh = mv && !kr;
        acc   = mv && kr;
        ev = 0; bad = 0; drop = 0; e_ext = 0; e_brk = 0; e_code = 0;
        mst = 0;
        if (rv) begin
            if (!(^fr[8:0]) || !fr[9]) begin
                bad = 1;
                pfx.delete();
            end else begin
                b = fr[7:0];
                has_e = 0; has_f = 0;
                foreach (pfx[i]) begin
                    if (pfx[i] == 8'hE0) has_e = 1;
                    if (pfx[i] == 8'hF0) has_f = 1;
                end
                if (!has_f && (b == 8'hE0 || b == 8'hF0)) begin
                    pfx.push_back(b);
                end else if (pfx.size() == 0 && is_stat(b)) begin
                    mst  = 1;
                    mstc = b;
                end else begin
                    ev = 1; e_code = b; e_ext = has_e; e_brk = has_f;
                    pfx.delete();
                end
            end
        end
        if (ev) begin
            if (!mv || acc) begin
                mv = 1; mcode = e_code; mext = e_ext; mbrk = e_brk;
            end else begin
                drop = 1;
            end
        end else if (acc) begin
            mv = 0;
        end
        if (drop) mov = 1;
        else if (ec) mov = 0;
        if (ec) merr = bad ? 8'd1 : 8'd0;
        else if (bad && merr != 8'hFF) merr = merr + 8'd1;
        minh = n_inh;
    endtask

    initial begin
        int nbad;
        int k;
        reset     = 1'b0;
        rx_valid  = 1'b0;
        rx_frame  = '0;
        key_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_outputs", {key_valid, key_code, key_ext, key_break, status_valid,
                                status_code, timeout, overflow, err_cnt, rx_inhibit}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        vt[0]  = '{8'h1C, 1, 1, 8'h1C, 0, 0, 0};
        vt[1]  = '{8'hE0, 1, 0, 8'h00, 0, 0, 0};
        vt[2]  = '{8'hF0, 1, 0, 8'h00, 0, 0, 0};
        vt[3]  = '{8'h75, 1, 1, 8'h75, 1, 1, 0};
        vt[4]  = '{8'hAA, 1, 0, 8'h00, 0, 0, 1};
        vt[5]  = '{8'hF0, 1, 0, 8'h00, 0, 0, 0};
        vt[6]  = '{8'hAA, 1, 1, 8'hAA, 0, 1, 0};
        vt[7]  = '{8'hE0, 1, 0, 8'h00, 0, 0, 0};
        vt[8]  = '{8'hE0, 1, 0, 8'h00, 0, 0, 0};
        vt[9]  = '{8'h6B, 1, 1, 8'h6B, 1, 0, 0};
        vt[10] = '{8'hF0, 1, 0, 8'h00, 0, 0, 0};
        vt[11] = '{8'h1C, 0, 0, 8'h00, 0, 0, 0};
        vt[12] = '{8'h1C, 1, 1, 8'h1C, 0, 0, 0};
        vt[13] = '{8'hFA, 1, 0, 8'h00, 0, 0, 1};
        vt[14] = '{8'hE0, 1, 0, 8'h00, 0, 0, 0};
        vt[15] = '{8'hFA, 1, 1, 8'hFA, 1, 0, 0};

        nbad = 0;
        for (int i = 0; i < 16; i++) begin
            send(mk_frame(vt[i].b, vt[i].good));
            if (!vt[i].good) nbad++;
            check($sformatf("vec%0d_valid", i), key_valid, vt[i].ev);
            check($sformatf("vec%0d_status", i), status_valid, vt[i].st);
            if (vt[i].ev) begin
                check($sformatf("vec%0d_key", i), {key_code, key_ext, key_break},
                      {vt[i].code, vt[i].ext, vt[i].brk});
            end
            if (vt[i].st) check($sformatf("vec%0d_stcode", i), status_code, vt[i].b);
        end
        check("vec_errcnt", err_cnt, nbad);

        // Saturation, clear, clear coincident with a bad frame
        for (int i = 0; i < 300; i++) send(mk_frame(8'h1C, 1'b0));
        check("err_saturate", err_cnt, 8'd255);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("err_clear", err_cnt, 8'd0);
        @(negedge clk);
        err_clr = 1'b1; rx_valid = 1'b1; rx_frame = mk_frame(8'h22, 1'b0);
        @(negedge clk);
        err_clr = 1'b0; rx_valid = 1'b0;
        check("err_clr_with_bad", err_cnt, 8'd1);

        // Overflow and back-pressure
        key_ready = 1'b0;
        send(mk_frame(8'h1C, 1'b1));
        send(mk_frame(8'h32, 1'b1));
        check("ovf_hold", {key_valid, key_code}, {1'b1, 8'h1C});
        check("ovf_flag", overflow, 1'b1);
        check("ovf_inhibit", rx_inhibit, 1'b1);
        key_ready = 1'b1;
        @(negedge clk);
        check("ovf_accept", {key_valid, rx_inhibit}, 2'b00);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("ovf_clear", overflow, 1'b0);

        // Watchdog after a lone F0
        send(mk_frame(8'hF0, 1'b1));
        k = 0;
        while (!timeout && k < T + 6) begin
            @(negedge clk);
            k++;
        end
        check("timeout_seen", timeout, 1'b1);
        check("timeout_window", (k >= T - 2 && k <= T + 2), 1'b1);
        @(negedge clk);
        check("timeout_pulse", timeout, 1'b0);
        send(mk_frame(8'h1C, 1'b1));
        check("after_timeout", {key_valid, key_code, key_break}, {1'b1, 8'h1C, 1'b0});

        // Reset mid-sequence and with a pending event
        send(mk_frame(8'hF0, 1'b1));
        do_reset();
        send(mk_frame(8'h1C, 1'b1));
        check("rst_mid_seq", {key_valid, key_break}, 2'b10);
        key_ready = 1'b0;
        send(mk_frame(8'h2A, 1'b1));
        do_reset();
        check("rst_pending", {key_valid, key_code, rx_inhibit}, 10'd0);

        // Randomized run against the model
        key_ready = 1'b1;
        do_reset();
        pfx.delete();
        mv = 0; mext = 0; mbrk = 0; mst = 0; mov = 0; minh = 0; mto = 0;
        mcode = 0; mstc = 0; merr = 0;
        begin
            int gap;
            logic rv, kr, ec;
            logic [9:0] fr;
            logic [7:0] b;
            gap = 0;
            for (int c = 0; c < 3000; c++) begin
                check($sformatf("rand_cyc%0d", c),
                      {key_valid, key_code, key_ext, key_break, status_valid,
                       status_code, timeout, overflow, err_cnt, rx_inhibit},
                      {mv, mcode, mext, mbrk, mst, mstc, mto, mov, merr, minh});
                kr = ($urandom_range(0, 3) != 0);
                ec = ($urandom_range(0, 63) == 0);
                rv = (gap >= 5) || ($urandom_range(0, 2) == 0);
                gap = rv ? 0 : gap + 1;
                case ($urandom_range(0, 7))
                    0: b = 8'hE0;
                    1: b = 8'hF0;
                    2: b = 8'hAA;
                    3: b = 8'hFA;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                fr = mk_frame(b, $urandom_range(0, 15) != 0);
                rx_valid  = rv;
                rx_frame  = fr;
                key_ready = kr;
                err_clr   = ec;
                model_step(rv, fr, kr, ec);
                @(negedge clk);
            end
            rx_valid = 1'b0;
            err_clr  = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequencing controller that sits directly behind the PS/2 frame receiver and turns raw 10-bit frames into validated key events. It checks parity and stop bits, decodes the set-2 prefix sequence (E0 extended, F0 break), separates device status bytes from key codes, and applies receive back-pressure toward the receiver. A one-entry output register with a valid/ready handshake feeds the downstream consumer; an inter-byte watchdog resynchronises the decoder after a truncated sequence.

## Interface
- TIMEOUT_CYCLES, 50000: maximum idle clk cycles between prefix bytes (1 ms at 50 MHz); min 2.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- rx_valid  in  1  single-cycle pulse: new frame from the receiver.
- rx_frame  in  10  [7:0] data byte (bit 0 = first data bit on the wire), [8] parity, [9] stop.
- rx_inhibit  out  1  high requests the receiver/line driver to hold PS/2 clock low.
- key_valid  out  1  key event pending.
- key_ready  in  1  consumer accepts when key_valid && key_ready.
- key_code  out  8  make/break code without prefixes.
- key_ext  out  1  E0 prefix seen.
- key_break  out  1  F0 prefix seen (release).
- status_valid  out  1  one-cycle pulse: device status byte received.
- status_code  out  8  status byte; holds last value.
- timeout  out  1  one-cycle pulse: watchdog returned decoder to IDLE.
- overflow  out  1  sticky: a key event was dropped.
- err_cnt  out  8  saturating count of bad frames.
- err_clr  in  1  clears err_cnt and overflow.

## Operation
- Frame good when odd parity holds over rx_frame[8:0] and rx_frame[9]=1. Bad frame: discarded, err_cnt+1 (saturate at 255), decoder -> IDLE.
- Decoder states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
- IDLE: E0 -> EXT; F0 -> BRK; status bytes 00, AA, EE, FA, FC, FE, FF -> status_valid pulse, stay IDLE; any other -> key event (ext=0, break=0).
- EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> key event (ext=1, break=0), -> IDLE.
- BRK: any byte -> key event (ext=0, break=1), -> IDLE. EXT_BRK: any byte -> event (ext=1, break=1), -> IDLE.
- Status bytes only recognised in IDLE; in other states they are key codes.
- Output register: event loaded when empty, or when the current entry is accepted in the same cycle (no bubble). Event arriving while full and not accepted: dropped, overflow set.
- rx_inhibit = key_valid && !key_ready, registered.
- Watchdog counts cycles while state != IDLE; cleared on every rx_valid; on reaching TIMEOUT_CYCLES-1 -> IDLE, timeout pulse.
- err_clr coincident with a bad frame: err_cnt becomes 1. err_clr coincident with overflow event: overflow stays 1.

## Timing
- Reset values: key_valid 0, key_code/key_ext/key_break 0, status_valid 0, status_code 0, timeout 0, overflow 0, err_cnt 0, rx_inhibit 0, state IDLE, watchdog 0.
- Latency: key_valid / status_valid rise the cycle after rx_valid.
- key_* fields stable while key_valid && !key_ready.
- rx_valid in the same cycle as watchdog expiry: frame wins, processed in the current prefix state; no timeout pulse.
- Reset mid-sequence or with key_valid high: all state discarded, pending event lost.
- rx_valid assumed ≥2 cycles apart; back-to-back handled correctly regardless.

## Structure
- ps2_pkg: decoder state enum, constants PS2_EXT=E0, PS2_BRK=F0, status code list, frame bit index constants.
- Sub-module ps2_watchdog: counter with clear, enable, and expiry pulse, parameterised by TIMEOUT_CYCLES, width $clog2(TIMEOUT_CYCLES).

## Test plan
- Frame 1C (parity 0, stop 1), key_ready=1 -> key_valid one cycle, key_code=1C, ext=0, break=0.
- E0, F0, 75 -> single event key_code=75, ext=1, break=1; no events for prefixes.
- Frame 1C with parity 1 -> no event, err_cnt=1; 300 bad frames -> err_cnt=255; err_clr -> 0.
- key_ready=0, frames 1C then 32 -> key_code stays 1C, overflow=1, rx_inhibit=1; then key_ready=1 -> accepted, rx_inhibit falls.
- F0 then silence TIMEOUT_CYCLES cycles -> timeout pulse; next 1C -> break=0.
- Frame AA in IDLE -> status_valid, status_code=AA, no key event; F0 AA -> key event code AA, break=1.
